// File: rtl/divider.sv
// Sequential 16/8 unsigned divider: restoring shift-subtract, one quotient
// bit per clock, MSB first. Result and status are registered and change only
// on the edge that enters DONE.
module divider #(
  parameter logic [15:0] DBZ_QUOT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in1,
  input  logic [7:0]  in2,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic [7:0]  rem,
  output logic        dbz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  // Dividend shifts out at the top while quotient bits shift in at the bottom,
  // so after 16 iterations this register holds the quotient.
  logic [15:0] dvd;
  logic [7:0]  dsr;
  logic [8:0]  partial;
  logic [4:0]  cnt;

  logic [8:0]  p;
  logic [8:0]  p_next;
  logic        q_bit;
  // The partial remainder is always below the divisor, so its top bit stays 0.
  logic        partial_top_unused;

  assign partial_top_unused = partial[8];

  // One restoring iteration: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    p      = {partial[7:0], dvd[15]};
    q_bit  = (p >= {1'b0, dsr});
    p_next = q_bit ? (p - {1'b0, dsr}) : p;
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dvd     <= '0;
      dsr     <= '0;
      partial <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      quot    <= '0;
      rem     <= '0;
      dbz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd     <= in1;
            dsr     <= in2;
            partial <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          partial <= p_next;
          dvd     <= {dvd[14:0], q_bit};
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd15) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (dsr == 8'd0) begin
              quot <= DBZ_QUOT;
              rem  <= 8'h00;
              dbz  <= 1'b1;
            end else begin
              quot <= {dvd[14:0], q_bit};
              rem  <= p_next[7:0];
              dbz  <= 1'b0;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: expected results come from a behavioural
// divide, queued at start and compared when done is seen.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in1;
  logic [7:0]  in2;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        dbz;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } res_t;

  res_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          excl_err = 0;
  logic [15:0] prev_q = 16'h0;

  divider #(.DBZ_QUOT(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .dbz(dbz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count done pulses and any cycle with busy and done together.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && done) excl_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One division; glitch=1 re-pulses start in RUN and in DONE with other operands.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input bit glitch);
    res_t e;
    res_t got;
    int   cyc;
    int   d0;
    if (b == 8'd0) begin
      e.q = 16'hFFFF; e.r = 8'h00; e.z = 1'b1;
    end else begin
      e.q = a / {8'd0, b}; e.r = 8'(a % {8'd0, b}); e.z = 1'b0;
    end
    sb.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; in1 = a; in2 = b;
    @(posedge clk); #1;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("quot_held", {16'd0, quot}, {16'd0, prev_q});
    start = 1'b0; in1 = 16'($urandom); in2 = 8'($urandom);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      cyc = i;
      if (glitch && i == 5) begin
        start = 1'b1; in1 = 16'd50; in2 = 8'd3;
      end
      if (glitch && i == 6) start = 1'b0;
      if (done) break;
    end
    chk("latency", cyc, 32'd16);
    got = sb.pop_front();
    chk("quot", {16'd0, quot}, {16'd0, got.q});
    chk("rem", {24'd0, rem}, {24'd0, got.r});
    chk("dbz", {31'd0, dbz}, {31'd0, got.z});
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    if (glitch) begin
      start = 1'b1; in1 = 16'd77; in2 = 8'd2;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_width", {31'd0, done}, 32'd0);
    chk("done_pulses", done_cnt - d0, 32'd1);
    prev_q = got.q;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", {16'd0, quot}, 32'd0);
    chk("rst_rem", {24'd0, rem}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    rst = 1'b1;

    // Directed values and boundaries, issued back to back.
    do_div(16'd1000, 8'd7, 1'b0);
    do_div(16'hFFFF, 8'hFF, 1'b0);
    do_div(16'd5, 8'd9, 1'b0);
    do_div(16'd1234, 8'd0, 1'b0);
    do_div(16'd100, 8'd10, 1'b0);
    do_div(16'd0, 8'd0, 1'b0);
    do_div(16'hFFFF, 8'd1, 1'b0);
    do_div(16'd0, 8'd1, 1'b0);
    do_div(16'd255, 8'd255, 1'b0);

    // Start re-pulsed in RUN and DONE must not disturb the result.
    do_div(16'd1000, 8'd7, 1'b1);
    begin
      int d0;
      d0 = done_cnt;
      repeat (25) @(posedge clk);
      #1;
      chk("no_extra_done", done_cnt - d0, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // A handful of random operands.
    for (int k = 0; k < 6; k++)
      do_div(16'($urandom), 8'($urandom_range(1, 255)), 1'b0);

    // Reset in the middle of RUN aborts without a done pulse.
    begin
      int d0;
      @(negedge clk);
      start = 1'b1; in1 = 16'd200; in2 = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      d0 = done_cnt;
      rst = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_quot", {16'd0, quot}, 32'd0);
      chk("abort_rem", {24'd0, rem}, 32'd0);
      chk("abort_dbz", {31'd0, dbz}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - d0, 32'd0);
      chk("abort_idle", {31'd0, busy}, 32'd0);
      prev_q = 16'h0;
    end
    do_div(16'd100, 8'd10, 1'b0);

    chk("busy_done_excl", excl_err, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
